// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler (package elevator_pkg).
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    DWELL  = 2'd2
  } state_t;

  localparam int DEF_NUM_FLOORS = 10;
  localparam int DEF_FLOOR_W    = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_next_floor_sel.sv
// Combinational SCAN search: nearest pending floor ahead in i_dir, else nearest
// floor on the other side with the direction flipped.
module elevator_next_floor_sel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_cur,
  input  logic                  i_dir,
  output logic [FLOOR_W-1:0]    o_target,
  output logic                  o_valid,
  output logic                  o_new_dir
);

  logic               w_up_v;
  logic               w_dn_v;
  logic [FLOOR_W-1:0] w_up_t;
  logic [FLOOR_W-1:0] w_dn_t;

  // Scanning toward the car leaves the nearest hit as the last assignment.
  always_comb begin
    w_up_v = 1'b0;
    w_up_t = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (i_pending[i] && (i > int'(i_cur))) begin
        w_up_v = 1'b1;
        w_up_t = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    w_dn_v = 1'b0;
    w_dn_t = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_pending[i] && (i < int'(i_cur))) begin
        w_dn_v = 1'b1;
        w_dn_t = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    o_valid   = 1'b0;
    o_target  = '0;
    o_new_dir = i_dir;
    if (i_dir == DIR_UP) begin
      if (w_up_v) begin
        o_valid  = 1'b1;
        o_target = w_up_t;
      end else if (w_dn_v) begin
        o_valid   = 1'b1;
        o_target  = w_dn_t;
        o_new_dir = DIR_DOWN;
      end
    end else begin
      if (w_dn_v) begin
        o_valid  = 1'b1;
        o_target = w_dn_t;
      end else if (w_up_v) begin
        o_valid   = 1'b1;
        o_target  = w_up_t;
        o_new_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler feeding an elevator car controller.
// Optional fire recall to floor 0 is built when SCHED_FIRE_RECALL_EN is defined.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int FLOOR_W      = DEF_FLOOR_W,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  moving,
`ifdef SCHED_FIRE_RECALL_EN
  input  logic                  fire_recall,
`endif
  output logic [FLOOR_W-1:0]    request_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  sched_dir,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int CNT_W = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES + 1);

  state_t                r_state;
  logic [FLOOR_W-1:0]    r_req;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_door;
  logic                  r_dir;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;

  state_t                w_state_nx;
  logic [FLOOR_W-1:0]    w_req_nx;
  logic [NUM_FLOORS-1:0] w_pending_nx;
  logic [NUM_FLOORS-1:0] w_clear;
  logic                  w_door_nx;
  logic                  w_dir_nx;
  logic [CNT_W-1:0]      w_cnt_nx;

  logic                  w_cur_ok;
  logic [FLOOR_W-1:0]    w_sel_target;
  logic                  w_sel_valid;
  logic                  w_sel_dir;
  logic                  w_between;

  // Out-of-range positions are "no floor": no arrival, no clear, no wrap.
  assign w_cur_ok = (int'(current_floor) < NUM_FLOORS);

  elevator_next_floor_sel #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_sel (
    .i_pending (r_pending),
    .i_cur     (current_floor),
    .i_dir     (r_dir),
    .o_target  (w_sel_target),
    .o_valid   (w_sel_valid),
    .o_new_dir (w_sel_dir)
  );

  // A nearer call ahead of the car, short of the current target, steals the stop.
  assign w_between = (r_dir == DIR_UP) ? (w_sel_target < r_req) : (w_sel_target > r_req);

`ifdef SCHED_FIRE_RECALL_EN
  logic r_recall;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    w_dir_nx   = r_dir;
    w_door_nx  = 1'b0;
    w_cnt_nx   = '0;
    w_clear    = '0;

    case (r_state)
      IDLE: begin
        w_req_nx = current_floor;
        if (w_cur_ok && r_pending[current_floor]) begin
          w_state_nx = DWELL;
        end else if (w_sel_valid) begin
          w_req_nx   = w_sel_target;
          w_dir_nx   = w_sel_dir;
          w_state_nx = TRAVEL;
        end
      end
      TRAVEL: begin
        if (w_cur_ok && (current_floor == r_req) && !moving) begin
          w_state_nx = DWELL;
        end else if (w_sel_valid && (w_sel_dir == r_dir) && w_between) begin
          w_req_nx = w_sel_target;
        end
      end
      DWELL: begin
        if (r_cnt == CNT_W'(DWELL_CYCLES)) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx  = r_cnt + 1'b1;
          w_door_nx = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase

`ifdef SCHED_FIRE_RECALL_EN
    // First recall cycle forces travel to floor 0; afterwards the FSM runs on
    // an empty call set and the door is held open once parked.
    if (fire_recall) begin
      if (!r_recall) begin
        w_state_nx = TRAVEL;
        w_req_nx   = '0;
        w_door_nx  = 1'b0;
        w_cnt_nx   = '0;
      end else if (w_state_nx == IDLE) begin
        w_req_nx  = (r_state == IDLE) ? current_floor : r_req;
        w_door_nx = 1'b1;
      end
    end
`endif

    if ((w_state_nx == DWELL) && w_cur_ok) begin
      w_clear = NUM_FLOORS'(1) << current_floor;
    end
    w_pending_nx = (r_pending | call_btn) & ~w_clear;

`ifdef SCHED_FIRE_RECALL_EN
    if (fire_recall) begin
      w_pending_nx = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_pending <= '0;
      r_door    <= 1'b0;
      r_dir     <= DIR_UP;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_req     <= w_req_nx;
      r_pending <= w_pending_nx;
      r_door    <= w_door_nx;
      r_dir     <= w_dir_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_cnt     <= w_cnt_nx;
    end
  end

`ifdef SCHED_FIRE_RECALL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_recall <= 1'b0;
    end else begin
      r_recall <= fire_recall;
    end
  end
`endif

  assign request_floor = r_req;
  assign pending       = r_pending;
  assign door_open     = r_door;
  assign sched_dir     = r_dir;
  assign busy          = r_busy;
  assign dbg_state     = r_state;

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Request-side counterpart of the elevator car controller.
- Latches floor call buttons and decides the service order with a SCAN policy: keep going in the current direction, reverse only when no calls remain ahead.
- Drives `request_floor` into the car controller and watches its `current_floor` and `moving` outputs to detect arrival.
- On arrival, clears the served call and holds the door open for a fixed dwell time.

Parameters:
- NUM_FLOORS, 10: number of served floors, 2..16; floor indices run 0..NUM_FLOORS-1.
- FLOOR_W, 4: width of floor index buses; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- DWELL_CYCLES, 4: door-open cycles per stop, >= 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset (asserted when 0, sampled on rising clk).
- call_btn  in  NUM_FLOORS  one bit per floor; a 1 in any cycle registers a call.
- current_floor  in  FLOOR_W  car position from the car controller.
- moving  in  1  car-moving status from the car controller.
- request_floor  out  FLOOR_W  target floor presented to the car controller.
- pending  out  NUM_FLOORS  registered outstanding calls.
- door_open  out  1  high during dwell.
- sched_dir  out  1  scan direction: 1 = up, 0 = down.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst = 0 at a clock edge): request_floor = 0, pending = 0, door_open = 0, sched_dir = 1, busy = 0, state = IDLE, dwell counter = 0. Reset mid-travel abandons all calls; no output is held across reset.
- Call latch, every cycle: pending_next = (pending | call_btn) & ~clear_mask.
  - clear_mask has the current_floor bit set only on the cycle the FSM enters or stays in DWELL.
  - A set and clear of the same bit in the same cycle resolves to clear.
- current_floor >= NUM_FLOORS: treated as no floor. Nothing is cleared, no arrival is detected, and there is no wrap-around.
- Target selection (combinational):
  - "ahead" = pending floors strictly above current_floor when sched_dir = 1, strictly below when sched_dir = 0. Pick the nearest ahead floor.
  - If none ahead, flip the direction and pick the nearest floor on the other side.
  - If none at all, there is no target.
- FSM:
  - IDLE:
    - request_floor is held equal to current_floor, so the car stays parked.
    - If pending[current_floor] = 1: go to DWELL.
    - Else if a target exists: request_floor <= target, update sched_dir, go to TRAVEL.
    - Else stay in IDLE.
  - TRAVEL:
    - Arrival is current_floor == request_floor && moving == 0; on arrival go to DWELL.
    - Retarget: if a newly pending floor lies strictly between current_floor and request_floor in sched_dir, request_floor <= that floor (nearest wins). Retarget is evaluated every cycle in TRAVEL.
    - Calls behind the car are left pending.
  - DWELL:
    - door_open = 1 for exactly DWELL_CYCLES cycles, then go to IDLE.
    - The current_floor bit is cleared on entry. Calls to the current floor during dwell are absorbed (cleared) and do not extend the dwell.
- Latency:
  - Press at the parked floor: door_open rises 1 cycle after entering DWELL.
  - Press elsewhere while IDLE: request_floor updates on the 2nd edge after the press (pending latches on edge 1, dispatch on edge 2).
- Simultaneous calls above and below while IDLE: the current sched_dir side wins.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: SCHED_FIRE_RECALL_EN.
- When defined, adds input port fire_recall (1 bit).
  - While fire_recall = 1: pending is forced to 0, call_btn is ignored, request_floor <= 0, state is forced to TRAVEL (DWELL is abandoned and door_open drops).
  - On arrival at floor 0, go to DWELL, then stay in IDLE with door_open = 1 until fire_recall = 0.
  - Normal operation resumes the cycle after deassertion.
- When undefined: no port and no logic; behaviour is exactly as above.

Decomposition:
- Package elevator_pkg holds:
  - the state enum {IDLE, TRAVEL, DWELL};
  - FLOOR_W, NUM_FLOORS defaults;
  - DIR_UP = 1 and DIR_DOWN = 0 constants.
- Sub-module elevator_next_floor_sel: purely combinational nearest-ahead / reverse search over pending. It outputs target, valid and new_dir, and is reused for the TRAVEL retarget check.

Test Plan:
- Reset, then car parked at floor 0, pulse call_btn[5] -> pending[5] = 1; request_floor = 5 two edges later; sched_dir = 1; busy = 1. When the car reports current_floor = 5 and moving = 0 -> door_open high for 4 cycles, pending = 0, then IDLE.
- Car travelling to 7, at floor 3, going up; press floor 5 -> request_floor retargets to 5. After the dwell at 5 it resumes to 7.
- Car at floor 4 going up with calls pending at 2 and 8 -> serves 8 first, then reverses (sched_dir = 0) and serves 2.
- Press at the current floor while IDLE -> no travel; request_floor stays equal to current_floor; DWELL of 4 cycles; the bit is cleared.
- rst = 0 asserted mid-TRAVEL with pending = 0x2A0 -> next edge: all outputs at reset values, pending = 0, request_floor = 0.
- With SCHED_FIRE_RECALL_EN: calls pending at 6 and 9, assert fire_recall -> pending cleared, request_floor = 0; the car arrives at 0 -> door_open held until fire_recall = 0.
